// File: rtl/cpu_pkg.sv
// Shared types and constants for the next-PC / status stage.
package cpu_pkg;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR = 32'h0000_0080;
    localparam logic [4:0]  LINK_REG    = 5'd31;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JIDX,
        SEL_RS,
        SEL_MEM,
        SEL_TRAP
    } pc_sel_e;

    typedef struct packed {
        logic z;
        logic n;
    } status_t;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_target_sel.sv
// Combinational next-PC select: priority-resolves the control strobes against
// the registered status flags and flags misaligned targets as SEL_TRAP.
module pc_target_sel
    import cpu_pkg::*;
(
    input  logic        jr,
    input  logic        jmadd,
    input  logic        jrsal,
    input  logic        balrz,
    input  logic        balmn,
    input  logic        branch,
    input  logic        op_bn,
    input  logic        alu_zero,
    input  status_t     stat,
    input  logic [31:0] pc_plus4,
    input  logic [25:0] jidx,
    input  logic [31:0] rs_val,
    input  logic [31:0] mem_rdata,
    output pc_sel_e     sel,
    output logic [31:0] target,
    output logic        link
);

    logic br_taken;
    assign br_taken = branch & (op_bn ? ~alu_zero : alu_zero);

    always_comb begin
        sel    = SEL_SEQ;
        target = pc_plus4;
        link   = 1'b0;
        if (jr) begin
            sel    = SEL_RS;
            target = rs_val;
        end else if (jmadd) begin
            sel    = SEL_MEM;
            target = mem_rdata;
        end else if (jrsal) begin
            sel    = SEL_MEM;
            target = mem_rdata;
            link   = 1'b1;
        end else if (balrz && stat.z) begin
            sel    = SEL_RS;
            target = rs_val;
            link   = 1'b1;
        end else if (balmn && stat.n) begin
            sel    = SEL_JIDX;
            target = {pc_plus4[31:28], jidx, 2'b00};
            link   = 1'b1;
        end else if (br_taken) begin
            sel    = SEL_BR;
            target = pc_plus4 + branch_offset(jidx[15:0]);
        end
        // A misaligned target keeps its link; only the PC is diverted.
        if (target[1:0] != 2'b00) begin
            sel = SEL_TRAP;
        end
    end

endmodule

// File: rtl/pc_status_unit.sv
// PC, Z/N status and EPC registers for the single-cycle datapath.
// Optional redirect counter enabled by defining REDIRECT_CNT_EN.
module pc_status_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = cpu_pkg::RESET_PC,
    parameter logic [31:0] TRAP_VECTOR = cpu_pkg::TRAP_VECTOR,
    parameter logic [4:0]  LINK_REG    = cpu_pkg::LINK_REG
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        op_bn,
    input  logic        balrz,
    input  logic        jr,
    input  logic        jrsal,
    input  logic        jmadd,
    input  logic        balmn,
    input  logic        noupdatestat,
    input  logic        alu_zero,
    input  logic        alu_neg,
    input  logic [31:0] rs_val,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        link_we,
    output logic [4:0]  link_addr,
    output logic [31:0] link_wdata,
    output logic        stat_z,
    output logic        stat_n,
    output logic [31:0] epc,
`ifdef REDIRECT_CNT_EN
    output logic [31:0] redirect_cnt,
`endif
    output logic        misalign
);

    logic [31:0] pc_reg;
    logic [31:0] epc_reg;
    logic        misalign_reg;
    status_t     stat_reg;

    pc_sel_e     sel;
    logic [31:0] target;
    logic        link;
    logic [31:0] pc_next;
    logic        unused_instr_hi;

    assign unused_instr_hi = ^instr[31:26];

    assign pc_plus4 = pc_reg + 32'd4;

    pc_target_sel u_sel (
        .jr        (jr),
        .jmadd     (jmadd),
        .jrsal     (jrsal),
        .balrz     (balrz),
        .balmn     (balmn),
        .branch    (branch),
        .op_bn     (op_bn),
        .alu_zero  (alu_zero),
        .stat      (stat_reg),
        .pc_plus4  (pc_plus4),
        .jidx      (instr[25:0]),
        .rs_val    (rs_val),
        .mem_rdata (mem_rdata),
        .sel       (sel),
        .target    (target),
        .link      (link)
    );

    assign pc_next = (sel == SEL_TRAP) ? TRAP_VECTOR : target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg       <= RESET_PC;
            stat_reg     <= '0;
            epc_reg      <= '0;
            misalign_reg <= 1'b0;
        end else if (!stall) begin
            pc_reg <= pc_next;
            if (!noupdatestat) begin
                stat_reg <= '{z: alu_zero, n: alu_neg};
            end
            if (sel == SEL_TRAP) begin
                epc_reg      <= pc_reg;
                misalign_reg <= 1'b1;
            end
        end
    end

`ifdef REDIRECT_CNT_EN
    logic [31:0] redirect_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt_reg <= '0;
        end else if (!stall && (pc_next != pc_plus4) && (redirect_cnt_reg != 32'hFFFF_FFFF)) begin
            redirect_cnt_reg <= redirect_cnt_reg + 32'd1;
        end
    end

    assign redirect_cnt = redirect_cnt_reg;
`endif

    assign pc         = pc_reg;
    assign stat_z     = stat_reg.z;
    assign stat_n     = stat_reg.n;
    assign epc        = epc_reg;
    assign misalign   = misalign_reg;
    assign link_we    = ~stall & rst_n & link;
    assign link_addr  = LINK_REG;
    assign link_wdata = pc_plus4;

endmodule

// File: tb/tb_pc_status_unit.sv
// Directed scoreboard bench for pc_status_unit: the driver queues the expected
// pre-edge state per cycle, a negedge monitor pops and compares.
module tb_pc_status_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [31:0] instr;
    logic        branch, op_bn, balrz, jr, jrsal, jmadd, balmn;
    logic        noupdatestat, alu_zero, alu_neg;
    logic [31:0] rs_val, mem_rdata;
    logic [31:0] pc, pc_plus4, link_wdata, epc;
    logic        link_we, stat_z, stat_n, misalign;
    logic [4:0]  link_addr;
`ifdef REDIRECT_CNT_EN
    logic [31:0] redirect_cnt;
`endif

    pc_status_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .instr        (instr),
        .branch       (branch),
        .op_bn        (op_bn),
        .balrz        (balrz),
        .jr           (jr),
        .jrsal        (jrsal),
        .jmadd        (jmadd),
        .balmn        (balmn),
        .noupdatestat (noupdatestat),
        .alu_zero     (alu_zero),
        .alu_neg      (alu_neg),
        .rs_val       (rs_val),
        .mem_rdata    (mem_rdata),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .link_we      (link_we),
        .link_addr    (link_addr),
        .link_wdata   (link_wdata),
        .stat_z       (stat_z),
        .stat_n       (stat_n),
        .epc          (epc),
`ifdef REDIRECT_CNT_EN
        .redirect_cnt (redirect_cnt),
`endif
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        lwe;
        logic        z;
        logic        n;
        logic [31:0] epc;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tname, input string what,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h", tname, what, act, req);
        end
    endtask

    // Monitor: state and link outputs are stable mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk(nm, "pc",         pc,                 e.pc);
                chk(nm, "pc_plus4",   pc_plus4,           e.pc + 32'd4);
                chk(nm, "link_we",    {31'd0, link_we},   {31'd0, e.lwe});
                chk(nm, "link_wdata", link_wdata,         e.pc + 32'd4);
                chk(nm, "link_addr",  {27'd0, link_addr}, 32'd31);
                chk(nm, "stat_z",     {31'd0, stat_z},    {31'd0, e.z});
                chk(nm, "stat_n",     {31'd0, stat_n},    {31'd0, e.n});
                chk(nm, "epc",        epc,                e.epc);
                chk(nm, "misalign",   {31'd0, misalign},  {31'd0, e.mis});
`ifdef REDIRECT_CNT_EN
                chk(nm, "redirect_cnt", redirect_cnt, e.cnt);
`endif
                $display("txn %-8s pc=0x%08h link_we=%0b z=%0b n=%0b epc=0x%08h mis=%0b",
                         nm, pc, link_we, stat_z, stat_n, epc, misalign);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
        stall = 0; instr = '0; branch = 0; op_bn = 0; balrz = 0; jr = 0;
        jrsal = 0; jmadd = 0; balmn = 0; noupdatestat = 0;
        alu_zero = 0; alu_neg = 0; rs_val = '0; mem_rdata = '0;
    endtask

    task automatic expect_state(input string nm, input logic [31:0] e_pc, input logic e_lwe,
                                input logic e_z, input logic e_n, input logic [31:0] e_epc,
                                input logic e_mis, input logic [31:0] e_cnt);
        exp_t e;
        e.pc = e_pc; e.lwe = e_lwe; e.z = e_z; e.n = e_n;
        e.epc = e_epc; e.mis = e_mis; e.cnt = e_cnt;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        rst_n = 0; stall = 0; instr = '0; branch = 0; op_bn = 0; balrz = 0;
        jr = 0; jrsal = 0; jmadd = 0; balmn = 0; noupdatestat = 0;
        alu_zero = 0; alu_neg = 0; rs_val = '0; mem_rdata = '0;

        // In reset: jrsal must not raise link_we.
        next_cycle(); jrsal = 1; mem_rdata = 32'h1002;
        expect_state("reset", 32'h0, 0, 0, 0, 32'h0, 0, 0);
        // Plain cycles, status follows ALU flags.
        next_cycle(); rst_n = 1; alu_zero = 1;
        expect_state("seq0", 32'h0, 0, 0, 0, 32'h0, 0, 0);
        next_cycle(); alu_neg = 1;
        expect_state("seq4", 32'h4, 0, 1, 0, 32'h0, 0, 0);
        next_cycle();
        expect_state("seq8", 32'h8, 0, 0, 1, 32'h0, 0, 0);
        next_cycle();
        expect_state("seqC", 32'hC, 0, 0, 0, 32'h0, 0, 0);
        // Branches: offset -2 words from 0x10 lands on 0x0C.
        next_cycle(); branch = 1; alu_zero = 1; instr = 32'h0000_FFFE;
        expect_state("beq_t", 32'h10, 0, 0, 0, 32'h0, 0, 0);
        next_cycle(); branch = 1; instr = 32'h0000_FFFE;
        expect_state("beq_nt", 32'hC, 0, 1, 0, 32'h0, 0, 1);
        next_cycle(); branch = 1; op_bn = 1; instr = 32'h0000_FFFE;
        expect_state("bn_t", 32'h10, 0, 0, 0, 32'h0, 0, 1);
        next_cycle(); branch = 1; op_bn = 1; alu_zero = 1; instr = 32'h0000_FFFE;
        expect_state("bn_nt", 32'hC, 0, 0, 0, 32'h0, 0, 2);
        // jr to 0x40 setting Z, then balrz taken with link.
        next_cycle(); jr = 1; rs_val = 32'h40; alu_zero = 1;
        expect_state("jr", 32'h10, 0, 1, 0, 32'h0, 0, 2);
        next_cycle(); balrz = 1; rs_val = 32'h200;
        expect_state("balrz_t", 32'h40, 1, 1, 0, 32'h0, 0, 3);
        // noupdatestat blocks Z; balrz ignores the live alu_zero.
        next_cycle(); noupdatestat = 1; alu_zero = 1;
        expect_state("noupd", 32'h200, 0, 0, 0, 32'h0, 0, 4);
        next_cycle(); balrz = 1; rs_val = 32'h300; alu_zero = 1;
        expect_state("balrz_nt", 32'h204, 0, 0, 0, 32'h0, 0, 4);
        // jmadd to 0x80, then misaligned jrsal traps with link and status update.
        next_cycle(); jmadd = 1; mem_rdata = 32'h80;
        expect_state("jmadd", 32'h208, 0, 1, 0, 32'h0, 0, 4);
        next_cycle(); jrsal = 1; mem_rdata = 32'h1002; alu_neg = 1;
        expect_state("jrsal_tr", 32'h80, 1, 0, 0, 32'h0, 0, 5);
        // Simultaneous strobes: jr wins, no link even though stat_n=1.
        next_cycle(); jr = 1; jmadd = 1; balmn = 1; rs_val = 32'h300; mem_rdata = 32'h400;
        expect_state("prio", 32'h80, 0, 0, 1, 32'h80, 1, 6);
        // Stall: everything holds, strobes ignored.
        next_cycle(); stall = 1; jr = 1; jrsal = 1; rs_val = 32'h500; alu_zero = 1;
        expect_state("stall", 32'h300, 0, 0, 0, 32'h80, 1, 7);
        next_cycle(); alu_neg = 1;
        expect_state("setn", 32'h300, 0, 0, 0, 32'h80, 1, 7);
        // balmn taken: jump index 0x100 -> 0x400.
        next_cycle(); balmn = 1; instr = 32'h0000_0100;
        expect_state("balmn_t", 32'h304, 1, 0, 1, 32'h80, 1, 7);
        // Mid-cycle async reset clears state immediately.
        next_cycle(); rst_n = 0; jr = 1; rs_val = 32'h700;
        expect_state("rst_mid", 32'h0, 0, 0, 0, 32'h0, 0, 0);
        next_cycle(); rst_n = 1;
        expect_state("post_rst", 32'h0, 0, 0, 0, 32'h0, 0, 0);
        next_cycle();
        expect_state("post_4", 32'h4, 0, 0, 0, 32'h0, 0, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_status_unit.md
Name: pc_status_unit

Overview:
Sequential next-PC and status-flag stage. It sits directly downstream of the main decoder (control) in the single-cycle datapath and consumes its branch and jump strobes. It holds the PC register, the Z/N status register, and the exception PC (EPC). It also drives the $31 link-write request for the link-style jumps.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TRAP_VECTOR, 32'h0000_0080, PC loaded on a misaligned redirect.
LINK_REG, 5'd31, register index used for link writes.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst_n  in  1  asynchronous, active-low reset.
stall  in  1  when 1, hold all state and suppress link_we.
instr  in  32  current instruction; bits [25:0] form the jump index.
branch  in  1  beq|bn from control.
op_bn  in  1  1 = bn (taken when not equal); 0 = beq.
balrz, jr, jrsal, jmadd, balmn  in  1 each  control strobes.
noupdatestat  in  1  blocks the status update this cycle.
alu_zero  in  1  ALU result is zero.
alu_neg  in  1  ALU result bit 31.
rs_val  in  32  register-file rs read data.
mem_rdata  in  32  data-memory read data (target for jrsal/jmadd).
pc  out  32  current PC.
pc_plus4  out  32  pc+4 (combinational).
link_we  out  1  register-file write request for LINK_REG.
link_addr  out  5  constant LINK_REG.
link_wdata  out  32  pc_plus4.
stat_z, stat_n  out  1 each  registered status flags.
epc  out  32  PC of the last misaligned redirect.
misalign  out  1  sticky misalign flag.

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_PC, stat_z=stat_n=0, epc=0, misalign=0. link_we is 0 while in reset.
- Each non-stalled cycle retires one instruction. Next-PC priority, highest first:
  1. jr -> rs_val
  2. jmadd -> mem_rdata
  3. jrsal -> mem_rdata, with link
  4. balrz & stat_z -> rs_val, with link
  5. balmn & stat_n -> {pc_plus4[31:28], instr[25:0], 2'b00}, with link
  6. branch & (op_bn ? ~alu_zero : alu_zero) -> pc_plus4 + {sext(instr[15:0]), 2'b00}
  7. otherwise pc_plus4
- Branch offset arithmetic is modulo 2^32; wrap-around is silent.
- balrz/balmn test the registered flags, i.e. the result of the prior updating instruction, never the live ALU flags.
- A balrz/balmn that is not taken produces no link write.
- link_we = ~stall & rst_n & (jrsal | balrz&stat_z | balmn&stat_n). The write takes effect in the same cycle; the register file captures it at the edge.
- Status update: if ~stall & ~noupdatestat, then stat_z<=alu_zero and stat_n<=alu_neg. Otherwise hold.
- Misalign: if the selected target has [1:0]!=0, then pc<=TRAP_VECTOR, epc<=current pc, misalign<=1.
  - The link write still occurs.
  - The status update still occurs.
  - misalign clears only on reset.
- Stall: pc, status, epc and misalign all hold. All strobes are ignored.
- Simultaneous strobes are resolved strictly by the priority list above.
- A reset assertion mid-cycle wins immediately over any update.

Optional Feature:
REDIRECT_CNT_EN:
- Defined: adds output redirect_cnt[31:0].
  - Resets to 0.
  - Increments on every non-stalled cycle whose next PC is not pc_plus4 (trap included).
  - Saturates at 32'hFFFF_FFFF.
- Undefined: no port and no counter logic.

Decomposition:
- Shared package cpu_pkg holds:
  - constants RESET_PC, TRAP_VECTOR, LINK_REG;
  - a 3-bit next-PC select enum (SEL_SEQ, SEL_BR, SEL_JIDX, SEL_RS, SEL_MEM, SEL_TRAP);
  - a status struct {z,n}.
- One natural sub-module, pc_target_sel: purely combinational. It computes the select and target from strobes and flags. The top level holds all registers.

Test Plan:
1. Reset, then 3 plain cycles with no strobes -> pc goes 0 -> 4 -> 8 -> C; stat tracks alu flags.
2. pc=0x10, beq, alu_zero=1, instr[15:0]=0xFFFE -> next pc=0x0C; with alu_zero=0 -> 0x14; bn inverts both cases.
3. ALU op with alu_zero=1, next cycle balrz with rs_val=0x200 at pc=0x40 -> pc=0x200, link_we=1, link_wdata=0x44, link_addr=31. Repeat with noupdatestat on the flag-setting op -> not taken, no link.
4. jrsal with mem_rdata=0x1002 at pc=0x80 -> pc=TRAP_VECTOR (0x80), epc=0x80, misalign=1, link_wdata=0x84.
5. jr, jmadd and balmn all asserted with rs_val=0x300, mem_rdata=0x400 -> pc=0x300, link_we=0. Then assert stall -> pc holds, link_we=0. Assert rst_n=0 mid-cycle -> pc=0 immediately.
6. With REDIRECT_CNT_EN: 2 taken branches, 1 not taken, 1 stalled jr -> redirect_cnt=2.
